falu_issue_ctrl: RTL and testbench
==================================

# falu_issue_ctrl

Issue controller that sits in front of the floating ALU top. It accepts one operation request at a time over a valid/ready handshake and registers the operands. It drives the ALU function code for exactly the latency of the selected unit, captures the unit's result, and returns it over a valid/ready response channel. Illegal function codes are rejected without touching the ALU.

## Interface
Parameters:
- OP_DATA_WIDTH, 32, operand/result width
- BASE_LAT, 1, cycles for single-cycle units (ADD, SUB, MUL, SGNJ*, MIN_MAX, CLASS, FMV*); range 1..15
- FMA_LAT, 2, cycles for FMADD/FNMADD/FMSUB/FNMSUB; range 1..15
- DIV_LAT, 2, cycles for DIV; range 1..15
- SQRT_LAT, 2, cycles for FSQRT; range 1..15

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept (IDLE only)
- req_func  in  5  function code, decoder bit order: 0 FMADD, 1 FNMADD, 2 FMSUB, 3 FNMSUB, 4 ADD, 5 SUB, 6 MUL, 7 DIV, 8 FSQRT, 9 FSGNJ, 10 FSGNJN, 11 FSGNJX, 12 MIN_MAX, 13 CLASS, 14 FMV_X_W, 15 FMV_W_X; 16..31 illegal
- req_a, req_b, req_c  in  OP_DATA_WIDTH  operands
- alu_func  out  5  to ALU_FUNC; 5'h1F (decodes to no enable) when not executing
- alu_a, alu_b, alu_c  out  OP_DATA_WIDTH  registered operands to ALU
- alu_res  in  OP_DATA_WIDTH  ALU output selected by the top-level mux using alu_func
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  OP_DATA_WIDTH  captured result (0 on error)
- rsp_func  out  5  function code of the response
- rsp_err  out  1  illegal function code
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE: req_ready=1. On req_valid: latch func, a, b, c. Legal code -> EXEC with cnt = LAT(func)-1. Illegal code -> RESP with rsp_err=1 and rsp_data=0; ALU untouched.
- EXEC: alu_func=latched func and alu_a/b/c stable. cnt decrements each cycle. On the cycle with cnt==0: alu_res captured into rsp_data, rsp_err=0, go to RESP.
- RESP: rsp_valid=1. rsp_data, rsp_func and rsp_err are held stable until rsp_valid&&rsp_ready, then go to IDLE. No new request is accepted in RESP (req_ready=0), even on the handshake cycle.
- alu_func=5'h1F in IDLE and RESP. alu_a/b/c keep their last values outside EXEC.
- LAT(func): FMA family -> FMA_LAT, 7 -> DIV_LAT, 8 -> SQRT_LAT, other legal codes -> BASE_LAT. The counter is 4 bits.

## Timing
- Reset: state IDLE, req_ready=1 after reset release, alu_func=5'h1F, alu_a/b/c=0, rsp_valid=0, rsp_data=0, rsp_func=0, rsp_err=0, busy=0.
- Legal op accepted at edge T: EXEC during cycles T+1..T+LAT, rsp_valid high from T+LAT+1. Minimum issue interval is LAT+2 cycles.
- Illegal op accepted at edge T: rsp_valid high from T+1.
- rsp_ready held low: RESP is held indefinitely with all response outputs stable.
- rsp_ready high on the first RESP cycle: one-cycle rsp_valid pulse, then req_ready=1 on the next cycle.
- req_valid while busy: ignored. The requester holds its request until req_ready.
- RST asserted mid-EXEC or mid-RESP: immediate return to reset values. The in-flight op is dropped and no response is issued.

## Structure
- Shared package falu_pkg: 5-bit function code localparams (F_FMADD..F_FMV_W_X, F_NOP=5'h1F), FSM state enum, and the latency-select function.
- Natural sub-module: falu_lat_lut (combinational; inputs func; outputs legal flag and 4-bit latency, with parameters passed down).
- One always block for the FSM and counter with async reset; one always block for the operand and response registers.

## Test plan
- ADD, a=32'h3F800000, b=32'h40000000, alu_res model 32'h40400000 -> alu_func=4 for exactly 1 cycle, rsp_valid 2 cycles after acceptance, rsp_data=32'h40400000, rsp_err=0.
- DIV with DIV_LAT=4 -> alu_func=7 for 4 consecutive cycles, rsp_valid at T+5, req_ready low from T+1 until after the response handshake.
- req_func=5'd20 -> alu_func stays 5'h1F throughout, rsp_valid at T+1, rsp_err=1, rsp_data=0, rsp_func=20.
- rsp_ready low for 10 cycles after FMADD completes -> rsp_data stable, rsp_valid high, alu_func=5'h1F, a second request ignored; accepted once rsp_ready is high for one cycle.
- RST pulled low during EXEC of FSQRT -> next cycle alu_func=5'h1F, busy=0, rsp_valid=0; after release a new ADD completes normally.
- Back-to-back random legal codes (16 ops, rsp_ready always high) -> each response's rsp_func matches its request, in order, with the spacing given by LAT(func)+2.

Source files
------------

// File: rtl/falu_pkg.sv
// Shared definitions for the floating ALU issue path: function codes,
// issue FSM states and the per-function latency selection.
package falu_pkg;

  localparam logic [4:0] F_FMADD   = 5'd0;
  localparam logic [4:0] F_FNMADD  = 5'd1;
  localparam logic [4:0] F_FMSUB   = 5'd2;
  localparam logic [4:0] F_FNMSUB  = 5'd3;
  localparam logic [4:0] F_ADD     = 5'd4;
  localparam logic [4:0] F_SUB     = 5'd5;
  localparam logic [4:0] F_MUL     = 5'd6;
  localparam logic [4:0] F_DIV     = 5'd7;
  localparam logic [4:0] F_FSQRT   = 5'd8;
  localparam logic [4:0] F_FSGNJ   = 5'd9;
  localparam logic [4:0] F_FSGNJN  = 5'd10;
  localparam logic [4:0] F_FSGNJX  = 5'd11;
  localparam logic [4:0] F_MIN_MAX = 5'd12;
  localparam logic [4:0] F_CLASS   = 5'd13;
  localparam logic [4:0] F_FMV_X_W = 5'd14;
  localparam logic [4:0] F_FMV_W_X = 5'd15;
  localparam logic [4:0] F_NOP     = 5'h1F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Illegal codes fall through to base; legality is decided separately.
  function automatic logic [3:0] lat_sel(
    input logic [4:0] func,
    input logic [3:0] base_lat,
    input logic [3:0] fma_lat,
    input logic [3:0] div_lat,
    input logic [3:0] sqrt_lat
  );
    case (func)
      F_FMADD, F_FNMADD, F_FMSUB, F_FNMSUB: lat_sel = fma_lat;
      F_DIV:                                lat_sel = div_lat;
      F_FSQRT:                              lat_sel = sqrt_lat;
      default:                              lat_sel = base_lat;
    endcase
  endfunction

endpackage

// File: rtl/falu_lat_lut.sv
// Combinational decode of a function code into a legal flag and the
// number of cycles the selected ALU unit needs.
module falu_lat_lut #(
  parameter int unsigned BASE_LAT = 1,
  parameter int unsigned FMA_LAT  = 2,
  parameter int unsigned DIV_LAT  = 2,
  parameter int unsigned SQRT_LAT = 2
) (
  input  logic [4:0] func,
  output logic       legal,
  output logic [3:0] lat
);
  import falu_pkg::*;

  localparam logic [3:0] BASE4 = 4'(BASE_LAT);
  localparam logic [3:0] FMA4  = 4'(FMA_LAT);
  localparam logic [3:0] DIV4  = 4'(DIV_LAT);
  localparam logic [3:0] SQRT4 = 4'(SQRT_LAT);

  always_comb begin
    legal = ~func[4];
    lat   = lat_sel(func, BASE4, FMA4, DIV4, SQRT4);
  end

endmodule

// File: rtl/falu_issue_ctrl.sv
// Issue controller in front of the floating ALU: accepts one request, holds
// the function code on the ALU for the unit latency, returns the result.
module falu_issue_ctrl #(
  parameter int unsigned OP_DATA_WIDTH = 32,
  parameter int unsigned BASE_LAT      = 1,
  parameter int unsigned FMA_LAT       = 2,
  parameter int unsigned DIV_LAT       = 2,
  parameter int unsigned SQRT_LAT      = 2
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [4:0]               req_func,
  input  logic [OP_DATA_WIDTH-1:0] req_a,
  input  logic [OP_DATA_WIDTH-1:0] req_b,
  input  logic [OP_DATA_WIDTH-1:0] req_c,
  output logic [4:0]               alu_func,
  output logic [OP_DATA_WIDTH-1:0] alu_a,
  output logic [OP_DATA_WIDTH-1:0] alu_b,
  output logic [OP_DATA_WIDTH-1:0] alu_c,
  input  logic [OP_DATA_WIDTH-1:0] alu_res,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [OP_DATA_WIDTH-1:0] rsp_data,
  output logic [4:0]               rsp_func,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [1:0]               dbg_state
);
  import falu_pkg::*;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // a requester holds valid and payload stable until ready, and the
  // controller holds the response stable until rsp_ready.

  state_t                   state_q, state_d;
  logic [3:0]               cnt_q, cnt_d;
  logic                     req_legal;
  logic [3:0]               req_lat;
  logic [4:0]               func_q;
  logic [OP_DATA_WIDTH-1:0] rsp_data_q;
  logic                     rsp_err_q;
  logic                     accept;
  logic                     exec_done;

  falu_lat_lut #(
    .BASE_LAT (BASE_LAT),
    .FMA_LAT  (FMA_LAT),
    .DIV_LAT  (DIV_LAT),
    .SQRT_LAT (SQRT_LAT)
  ) u_lat_lut (
    .func  (req_func),
    .legal (req_legal),
    .lat   (req_lat)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (req_legal) begin
            state_d = ST_EXEC;
            cnt_d   = req_lat - 4'd1;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) state_d = ST_RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == ST_IDLE);
    rsp_valid = (state_q == ST_RESP);
    busy      = (state_q != ST_IDLE);
    alu_func  = (state_q == ST_EXEC) ? func_q : F_NOP;
    dbg_state = state_q;
  end

  assign accept    = (state_q == ST_IDLE) && req_valid;
  assign exec_done = (state_q == ST_EXEC) && (cnt_q == 4'd0);

  // Operands only move for legal codes so a rejected op leaves the ALU inputs alone.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      func_q     <= 5'd0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_c      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        func_q <= req_func;
        if (req_legal) begin
          alu_a <= req_a;
          alu_b <= req_b;
          alu_c <= req_c;
        end else begin
          rsp_data_q <= '0;
          rsp_err_q  <= 1'b1;
        end
      end
      if (exec_done) begin
        rsp_data_q <= alu_res;
        rsp_err_q  <= 1'b0;
      end
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_func = func_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_falu_issue_ctrl.sv
// Self-checking bench for falu_issue_ctrl with a latency-aware ALU stub and
// a reference model of issue timing and response contents.
module tb_falu_issue_ctrl;

  localparam int W        = 32;
  localparam int BASE_LAT = 1;
  localparam int FMA_LAT  = 3;
  localparam int DIV_LAT  = 4;
  localparam int SQRT_LAT = 2;
  localparam logic [4:0] NOP = 5'h1F;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [4:0]   req_func = 5'd0;
  logic [W-1:0] req_a = '0, req_b = '0, req_c = '0;
  logic [4:0]   alu_func;
  logic [W-1:0] alu_a, alu_b, alu_c, alu_res;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_data;
  logic [4:0]   rsp_func;
  logic         rsp_err;
  logic         busy;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int unsigned run_q;
  logic [W-1:0] last_a = '0, last_b = '0, last_c = '0;
  logic [W+4:0] exp_q[$];

  falu_issue_ctrl #(
    .OP_DATA_WIDTH (W),
    .BASE_LAT      (BASE_LAT),
    .FMA_LAT       (FMA_LAT),
    .DIV_LAT       (DIV_LAT),
    .SQRT_LAT      (SQRT_LAT)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_func  (req_func),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_c     (req_c),
    .alu_func  (alu_func),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c     (alu_c),
    .alu_res   (alu_res),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_func  (rsp_func),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic int ref_lat(input logic [4:0] f);
    if (f <= 5'd3)       return FMA_LAT;
    else if (f == 5'd7)  return DIV_LAT;
    else if (f == 5'd8)  return SQRT_LAT;
    else                 return BASE_LAT;
  endfunction

  function automatic logic [W-1:0] ref_alu(input logic [4:0] f, input logic [W-1:0] a, b, c);
    if (f == 5'd4 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
    return (a + (b * 32'd3)) ^ c ^ {27'd0, f};
  endfunction

  // ALU stub: only the last cycle of a full-latency run gives the true result.
  always @(posedge CLK or negedge RST) begin
    if (!RST)               run_q <= 0;
    else if (alu_func == NOP) run_q <= 0;
    else                    run_q <= run_q + 1;
  end

  always_comb begin
    if (alu_func != NOP && run_q == 32'(ref_lat(alu_func) - 1))
      alu_res = ref_alu(alu_func, alu_a, alu_b, alu_c);
    else
      alu_res = 32'hDEAD0000 ^ run_q;
  end

  // ---------------- driver ----------------
  task automatic run_op(
    input  logic [4:0]   f,
    input  logic [W-1:0] a, b, c,
    input  int           hold,
    output int           lat_obs,
    output int           exec_cyc,
    output bit           func_ok,
    output bit           ops_ok,
    output bit           hold_ok,
    output bit           idle_ok,
    output logic [W-1:0] data,
    output logic         err,
    output logic [4:0]   rfunc,
    output int           acc_cyc
  );
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge CLK);
      n++;
    end
    req_valid = 1'b1; req_func = f; req_a = a; req_b = b; req_c = c;
    @(negedge CLK);
    acc_cyc = cyc;
    req_valid = 1'b0;
    req_func = 5'($urandom_range(0, 31));
    req_a = $urandom; req_b = $urandom; req_c = $urandom;
    if (f < 5'd16) begin last_a = a; last_b = b; last_c = c; end
    lat_obs = 0; exec_cyc = 0; func_ok = 1; ops_ok = 1; hold_ok = 1; idle_ok = 0;
    while (lat_obs < 40) begin
      lat_obs++;
      if (rsp_valid === 1'b1) break;
      if (alu_func !== NOP) begin
        exec_cyc++;
        if (alu_func !== f) func_ok = 0;
        if (alu_a !== a || alu_b !== b || alu_c !== c) ops_ok = 0;
      end
      if (req_ready !== 1'b0) ops_ok = 0;
      @(negedge CLK);
    end
    data = rsp_data; err = rsp_err; rfunc = rsp_func;
    if (rsp_valid !== 1'b1) begin
      hold_ok = 0;
      return;
    end
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_func = 5'd4; req_a = $urandom; req_b = $urandom; req_c = $urandom;
      @(negedge CLK);
      if (rsp_valid !== 1'b1 || rsp_data !== data || rsp_func !== rfunc || rsp_err !== err ||
          alu_func !== NOP || req_ready !== 1'b0 || busy !== 1'b1)
        hold_ok = 0;
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    idle_ok = (req_ready === 1'b1 && rsp_valid === 1'b0 && busy === 1'b0 && alu_func === NOP);
    req_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    checks++; if (alu_func !== NOP) begin failures++; $display("FAIL reset_alu_func got=%h exp=1f", alu_func); end
    checks++; if ({alu_a, alu_b, alu_c} !== '0) begin failures++; $display("FAIL reset_alu_ops got=%h/%h/%h exp=0", alu_a, alu_b, alu_c); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL reset_flags got=v%b e%b b%b exp=000", rsp_valid, rsp_err, busy); end
    checks++; if (rsp_data !== '0 || rsp_func !== 5'd0) begin failures++; $display("FAIL reset_rsp got=%h/%h exp=0/0", rsp_data, rsp_func); end
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL reset_release got=r%b b%b exp=r1 b0", req_ready, busy); end
  endtask

  task automatic test_add();
    int lat_obs, exec_cyc, acc;
    bit func_ok, ops_ok, hold_ok, idle_ok;
    logic [W-1:0] data; logic err; logic [4:0] rf;
    run_op(5'd4, 32'h3F800000, 32'h40000000, 32'h0, 0, lat_obs, exec_cyc, func_ok, ops_ok, hold_ok, idle_ok, data, err, rf, acc);
    checks++; if (exec_cyc !== 1 || !func_ok) begin failures++; $display("FAIL add_exec got=%0d cycles ok=%0d exp=1 ok=1", exec_cyc, func_ok); end
    checks++; if (lat_obs !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", lat_obs); end
    checks++; if (data !== 32'h40400000 || err !== 1'b0 || rf !== 5'd4) begin failures++; $display("FAIL add_rsp got=%h e%b f%0d exp=40400000 e0 f4", data, err, rf); end
    checks++; if (!ops_ok || !idle_ok) begin failures++; $display("FAIL add_ops_idle got=%0d/%0d exp=1/1", ops_ok, idle_ok); end
  endtask

  task automatic test_div();
    int lat_obs, exec_cyc, acc;
    bit func_ok, ops_ok, hold_ok, idle_ok;
    logic [W-1:0] data, a, b, c; logic err; logic [4:0] rf;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; c = $urandom;
      run_op(5'd7, a, b, c, i, lat_obs, exec_cyc, func_ok, ops_ok, hold_ok, idle_ok, data, err, rf, acc);
      checks++; if (exec_cyc !== DIV_LAT || !func_ok) begin failures++; $display("FAIL div_exec got=%0d ok=%0d exp=%0d", exec_cyc, func_ok, DIV_LAT); end
      checks++; if (lat_obs !== DIV_LAT + 1) begin failures++; $display("FAIL div_latency got=%0d exp=%0d", lat_obs, DIV_LAT + 1); end
      checks++; if (data !== ref_alu(5'd7, a, b, c) || err !== 1'b0) begin failures++; $display("FAIL div_data got=%h e%b exp=%h e0", data, err, ref_alu(5'd7, a, b, c)); end
      checks++; if (!ops_ok || !hold_ok || !idle_ok) begin failures++; $display("FAIL div_handshake got=%0d%0d%0d exp=111", ops_ok, hold_ok, idle_ok); end
    end
  endtask

  task automatic test_illegal();
    int lat_obs, exec_cyc, acc;
    bit func_ok, ops_ok, hold_ok, idle_ok;
    logic [W-1:0] data, pa, pb, pc; logic err; logic [4:0] rf, f;
    for (int i = 0; i < 4; i++) begin
      f = (i == 0) ? 5'd20 : 5'($urandom_range(16, 31));
      pa = last_a; pb = last_b; pc = last_c;
      run_op(f, $urandom, $urandom, $urandom, i, lat_obs, exec_cyc, func_ok, ops_ok, hold_ok, idle_ok, data, err, rf, acc);
      checks++; if (exec_cyc !== 0) begin failures++; $display("FAIL illegal_alu_func got=%0d exec cycles exp=0", exec_cyc); end
      checks++; if (lat_obs !== 1) begin failures++; $display("FAIL illegal_latency got=%0d exp=1", lat_obs); end
      checks++; if (data !== '0 || err !== 1'b1 || rf !== f) begin failures++; $display("FAIL illegal_rsp got=%h e%b f%0d exp=0 e1 f%0d", data, err, rf, f); end
      checks++; if (alu_a !== pa || alu_b !== pb || alu_c !== pc) begin failures++; $display("FAIL illegal_ops_touched got=%h exp=%h", alu_a, pa); end
      checks++; if (!hold_ok || !idle_ok) begin failures++; $display("FAIL illegal_handshake got=%0d%0d exp=11", hold_ok, idle_ok); end
    end
  endtask

  task automatic test_hold();
    int lat_obs, exec_cyc, acc;
    bit func_ok, ops_ok, hold_ok, idle_ok;
    logic [W-1:0] data, a, b, c; logic err; logic [4:0] rf;
    a = $urandom; b = $urandom; c = $urandom;
    run_op(5'd0, a, b, c, 10, lat_obs, exec_cyc, func_ok, ops_ok, hold_ok, idle_ok, data, err, rf, acc);
    checks++; if (exec_cyc !== FMA_LAT || lat_obs !== FMA_LAT + 1) begin failures++; $display("FAIL hold_timing got=%0d/%0d exp=%0d/%0d", exec_cyc, lat_obs, FMA_LAT, FMA_LAT + 1); end
    checks++; if (data !== ref_alu(5'd0, a, b, c) || rf !== 5'd0) begin failures++; $display("FAIL hold_data got=%h f%0d exp=%h f0", data, rf, ref_alu(5'd0, a, b, c)); end
    checks++; if (!hold_ok) begin failures++; $display("FAIL hold_stable got=%0d exp=1", hold_ok); end
    checks++; if (!idle_ok) begin failures++; $display("FAIL hold_release got=%0d exp=1", idle_ok); end
  endtask

  task automatic test_reset_mid_exec();
    int lat_obs, exec_cyc, acc;
    bit func_ok, ops_ok, hold_ok, idle_ok;
    logic [W-1:0] data; logic err; logic [4:0] rf;
    req_valid = 1'b1; req_func = 5'd8; req_a = $urandom; req_b = $urandom; req_c = $urandom;
    @(negedge CLK);
    req_valid = 1'b0;
    checks++; if (busy !== 1'b1 || alu_func !== 5'd8) begin failures++; $display("FAIL sqrt_started got=b%b f%h exp=b1 f08", busy, alu_func); end
    RST = 1'b0;
    #1;
    checks++; if (alu_func !== NOP || busy !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_reset got=f%h b%b v%b exp=f1f b0 v0", alu_func, busy, rsp_valid); end
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_reset_dropped got=v%b b%b exp=v0 b0", rsp_valid, busy); end
    run_op(5'd4, 32'h3F800000, 32'h40000000, 32'h1, 0, lat_obs, exec_cyc, func_ok, ops_ok, hold_ok, idle_ok, data, err, rf, acc);
    checks++; if (data !== 32'h40400000 || lat_obs !== 2 || !idle_ok) begin failures++; $display("FAIL post_reset_add got=%h lat%0d idle%0d exp=40400000 lat2 idle1", data, lat_obs, idle_ok); end
  endtask

  task automatic test_back_to_back();
    int lat_obs, exec_cyc, acc, prev_acc;
    bit func_ok, ops_ok, hold_ok, idle_ok;
    logic [W-1:0] data, a, b, c; logic err; logic [4:0] rf, f, prev_f;
    logic [W+4:0] exp;
    prev_acc = 0; prev_f = 5'd0;
    for (int i = 0; i < 16; i++) begin
      f = 5'($urandom_range(0, 15));
      a = $urandom; b = $urandom; c = $urandom;
      exp_q.push_back({f, ref_alu(f, a, b, c)});
      run_op(f, a, b, c, 0, lat_obs, exec_cyc, func_ok, ops_ok, hold_ok, idle_ok, data, err, rf, acc);
      exp = exp_q.pop_front();
      checks++; if ({rf, data} !== exp || err !== 1'b0) begin failures++; $display("FAIL b2b_rsp[%0d] got=%h e%b exp=%h e0", i, {rf, data}, err, exp); end
      checks++; if (lat_obs !== ref_lat(f) + 1 || exec_cyc !== ref_lat(f) || !func_ok) begin failures++; $display("FAIL b2b_latency[%0d] f%0d got=%0d/%0d exp=%0d", i, f, lat_obs, exec_cyc, ref_lat(f) + 1); end
      if (i > 0) begin
        checks++; if (acc - prev_acc !== ref_lat(prev_f) + 2) begin failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=%0d", i, acc - prev_acc, ref_lat(prev_f) + 2); end
      end
      prev_acc = acc; prev_f = f;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_add();
    test_div();
    test_illegal();
    test_hold();
    test_reset_mid_exec();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
